// File: rtl/stack_resolver.sv
// Stacker game resolver: trims a stopped row against the row below, commits it
// to the stack grid, scores it, and hands the trimmed row back upstream.
module stack_resolver #(
    parameter int                 WIDTH      = 8,
    parameter int                 ROWS       = 8,
    parameter logic [WIDTH-1:0]   INIT_BLOCK = 8'b00111000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     newGame,
    input  logic                     placeValid,
    input  logic [WIDTH-1:0]         placedRow,
    output logic [WIDTH-1:0]         nextBlock,
    output logic                     spawnReq,
    output logic                     busy,
    output logic [$clog2(ROWS):0]    level,
    output logic [7:0]               score,
    output logic [WIDTH*ROWS-1:0]    gridFlat,
    output logic                     gameOver,
    output logic                     gameWon
);

    localparam int IW = $clog2(ROWS);
    localparam int LW = IW + 1;

    typedef enum logic [2:0] {IDLE, WAIT, TRIM, COMMIT, CHECK, OVER, WON} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   grid_q [ROWS];
    logic [WIDTH-1:0]   grid_d [ROWS];
    logic [LW-1:0]      level_q, level_d;
    logic [7:0]         score_q, score_d;
    logic [WIDTH-1:0]   row_q, row_d;
    logic [WIDTH-1:0]   nextBlock_q, nextBlock_d;
    logic               spawn_q, spawn_d;
    logic               busy_q, busy_d;
    logic               over_q, over_d;
    logic               won_q, won_d;

    logic [LW-1:0]      belowLevel;
    logic [LW-1:0]      levelInc;
    logic [8:0]         ones;
    logic [8:0]         scoreSum;

    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        level_d     = level_q;
        score_d     = score_q;
        row_d       = row_q;
        nextBlock_d = nextBlock_q;
        spawn_d     = 1'b0;
        over_d      = over_q;
        won_d       = won_q;

        belowLevel = level_q - LW'(1);
        levelInc   = level_q + LW'(1);
        ones       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + 9'(row_q[i]);
        end
        scoreSum = {1'b0, score_q} + ones;

        unique case (state_q)
            WAIT: begin
                if (placeValid) begin
                    row_d   = placedRow;
                    state_d = TRIM;
                end
            end
            TRIM: begin
                if (level_q != '0) begin
                    row_d = row_q & grid_q[belowLevel[IW-1:0]];
                end
                state_d = COMMIT;
            end
            COMMIT: begin
                grid_d[level_q[IW-1:0]] = row_q;
                level_d     = levelInc;
                score_d     = scoreSum[8] ? 8'hFF : scoreSum[7:0];
                nextBlock_d = row_q;
                // spawnReq is registered, so the continue decision is made one cycle early to land in CHECK
                spawn_d     = (row_q != '0) && (levelInc != LW'(ROWS));
                state_d     = CHECK;
            end
            CHECK: begin
                if (row_q == '0) begin
                    over_d  = 1'b1;
                    state_d = OVER;
                end else if (level_q == LW'(ROWS)) begin
                    won_d   = 1'b1;
                    state_d = WON;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (newGame) begin
            for (int r = 0; r < ROWS; r++) begin
                grid_d[r] = '0;
            end
            level_d     = '0;
            score_d     = '0;
            row_d       = '0;
            nextBlock_d = INIT_BLOCK;
            spawn_d     = 1'b1;
            over_d      = 1'b0;
            won_d       = 1'b0;
            state_d     = WAIT;
        end

        busy_d = (state_d == TRIM) || (state_d == COMMIT) || (state_d == CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int r = 0; r < ROWS; r++) begin
                grid_q[r] <= '0;
            end
            level_q     <= '0;
            score_q     <= '0;
            row_q       <= '0;
            nextBlock_q <= INIT_BLOCK;
            spawn_q     <= 1'b0;
            busy_q      <= 1'b0;
            over_q      <= 1'b0;
            won_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grid_q      <= grid_d;
            level_q     <= level_d;
            score_q     <= score_d;
            row_q       <= row_d;
            nextBlock_q <= nextBlock_d;
            spawn_q     <= spawn_d;
            busy_q      <= busy_d;
            over_q      <= over_d;
            won_q       <= won_d;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_flat
        assign gridFlat[r*WIDTH +: WIDTH] = grid_q[r];
    end

    assign nextBlock = nextBlock_q;
    assign spawnReq  = spawn_q;
    assign busy      = busy_q;
    assign level     = level_q;
    assign score     = score_q;
    assign gameOver  = over_q;
    assign gameWon   = won_q;

endmodule

// File: tb/tb_stack_resolver.sv
// Self-checking bench for stack_resolver: directed game scenarios plus random
// games compared against a row-by-row behavioural model of the stack.
module tb_stack_resolver;

    localparam logic [7:0] INIT = 8'b00111000;

    logic        clk = 1'b0;
    logic        rst, newGame, placeValid;
    logic [7:0]  placedRow;
    logic [7:0]  nextBlock;
    logic        spawnReq, busy, gameOver, gameWon;
    logic [3:0]  level;
    logic [7:0]  score;
    logic [63:0] gridFlat;

    int checks = 0;
    int errors = 0;

    logic [7:0] mGrid [8];
    int         mLevel, mScore;
    logic [7:0] mNext;
    logic       mOver, mWon, mActive;

    always #5 clk = ~clk;

    stack_resolver dut (
        .clk        (clk),
        .rst        (rst),
        .newGame    (newGame),
        .placeValid (placeValid),
        .placedRow  (placedRow),
        .nextBlock  (nextBlock),
        .spawnReq   (spawnReq),
        .busy       (busy),
        .level      (level),
        .score      (score),
        .gridFlat   (gridFlat),
        .gameOver   (gameOver),
        .gameWon    (gameWon)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] modelFlat();
        logic [63:0] f;
        for (int r = 0; r < 8; r++) f[r*8 +: 8] = mGrid[r];
        return f;
    endfunction

    task automatic checkAll(input string tag, input logic expSpawn, input logic expBusy,
                            input logic expOver, input logic expWon);
        checkOutput({tag, ".level"},     64'(level),     64'(mLevel));
        checkOutput({tag, ".score"},     64'(score),     64'(mScore));
        checkOutput({tag, ".grid"},      gridFlat,       modelFlat());
        checkOutput({tag, ".nextBlock"}, 64'(nextBlock), 64'(mNext));
        checkOutput({tag, ".spawnReq"},  64'(spawnReq),  64'(expSpawn));
        checkOutput({tag, ".busy"},      64'(busy),      64'(expBusy));
        checkOutput({tag, ".gameOver"},  64'(gameOver),  64'(expOver));
        checkOutput({tag, ".gameWon"},   64'(gameWon),   64'(expWon));
    endtask

    task automatic applyStimulus(input logic ng, input logic pv, input logic [7:0] row);
        newGame    = ng;
        placeValid = pv;
        placedRow  = row;
        tick();
        newGame    = 1'b0;
        placeValid = 1'b0;
        placedRow  = 8'($urandom);
    endtask

    task automatic modelReset();
        for (int r = 0; r < 8; r++) mGrid[r] = 8'h00;
        mLevel  = 0;
        mScore  = 0;
        mNext   = INIT;
        mOver   = 1'b0;
        mWon    = 1'b0;
        mActive = 1'b0;
    endtask

    task automatic startGame(input string tag);
        applyStimulus(1'b1, 1'b0, 8'h00);
        modelReset();
        mActive = 1'b1;
        checkAll(tag, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // One placement: the model decides whether it is accepted and what it leaves behind.
    task automatic placeRow(input logic [7:0] row, input string tag);
        logic       accepted;
        logic [7:0] trimmed;
        accepted = mActive && !mOver && !mWon;
        applyStimulus(1'b0, 1'b1, row);
        if (accepted) begin
            trimmed = (mLevel == 0) ? row : (row & mGrid[mLevel-1]);
            mGrid[mLevel] = trimmed;
            mLevel++;
            mScore += $countones(trimmed);
            if (mScore > 255) mScore = 255;
            mNext = trimmed;
            if (trimmed == 8'h00) mOver = 1'b1;
            else if (mLevel == 8) mWon = 1'b1;
            checkOutput({tag, ".busyTrim"}, 64'(busy), 64'd1);
            placeValid = 1'($urandom);
            placedRow  = 8'($urandom);
            tick();
            tick();
            placeValid = 1'b0;
            checkAll({tag, ".check"}, !mOver && !mWon, 1'b1, 1'b0, 1'b0);
            tick();
            checkAll({tag, ".done"}, 1'b0, 1'b0, mOver, mWon);
        end else begin
            tick();
            tick();
            tick();
            checkAll({tag, ".ignored"}, 1'b0, 1'b0, mOver, mWon);
        end
    endtask

    initial begin
        logic [7:0] row;
        rst        = 1'b1;
        newGame    = 1'b0;
        placeValid = 1'b0;
        placedRow  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        modelReset();
        checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        placeRow(8'hFF, "idlePlace");

        startGame("t1");
        placeRow(8'b00111000, "t2");
        placeRow(8'b00011100, "t3");
        checkOutput("t3.grid1", 64'(gridFlat[15:8]), 64'(8'b00011000));
        checkOutput("t3.score", 64'(score), 64'd5);
        placeRow(8'b11000000, "t4");
        checkOutput("t4.gameOver", 64'(gameOver), 64'd1);
        placeRow(8'hFF, "t4post");

        startGame("t5start");
        for (int i = 0; i < 8; i++) placeRow(8'b00111000, $sformatf("t5row%0d", i));
        checkOutput("t5.score", 64'(score), 64'd24);
        checkOutput("t5.level", 64'(level), 64'd8);
        checkOutput("t5.gameWon", 64'(gameWon), 64'd1);
        placeRow(8'b00111000, "t5post");
        startGame("t5clear");

        applyStimulus(1'b1, 1'b1, 8'hFF);
        checkAll("t6.ngWins", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkAll("t6.ngWinsNext", 1'b0, 1'b0, 1'b0, 1'b0);

        placeRow(8'b01111000, "t6pre");
        applyStimulus(1'b0, 1'b1, 8'b00111000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelReset();
        checkAll("t6.rstCommit", 1'b0, 1'b0, 1'b0, 1'b0);

        for (int g = 0; g < 6; g++) begin
            startGame($sformatf("rnd%0d.start", g));
            for (int s = 0; s < 9; s++) begin
                if (mOver || mWon) break;
                case ($urandom_range(0, 3))
                    0:       row = 8'($urandom);
                    1:       row = mNext << 1;
                    2:       row = mNext >> 1;
                    default: row = mNext;
                endcase
                repeat ($urandom_range(0, 2)) tick();
                placeRow(row, $sformatf("rnd%0d_%0d", g, s));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
